// File: rtl/seq_serializer.sv
// Parallel-to-serial framer feeding the sequence detector: WIDTH-bit words out as a bit stream.
// Optional even-parity trailer bit is enabled with the SEQ_SERIALIZER_PARITY_EN macro.
module seq_serializer #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             ser_out,
   output logic             bit_valid,
   output logic             frame_done,
   output logic [7:0]       frames_sent
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef SEQ_SERIALIZER_PARITY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_shift, w_shift_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic             r_ser, w_ser_nxt;
   logic             r_valid, w_valid_nxt;
   logic             r_done, w_done_nxt;
   logic             r_ready, w_ready_nxt;
   logic [7:0]       r_frames, w_frames_nxt;
   logic             w_accept;
   logic             w_last;
`ifdef SEQ_SERIALIZER_PARITY_EN
   logic             r_parity, w_parity_nxt;
`endif

   // Ready is registered (true in IDLE and on the final frame cycle) but forced low during reset.
   assign load_ready  = r_ready & ~reset;
   assign w_accept    = load_valid & load_ready;
   assign ser_out     = r_ser;
   assign bit_valid   = r_valid;
   assign frame_done  = r_done;
   assign frames_sent = r_frames;

   // Next-state and next-output logic; each register's value for the coming cycle.
   always_comb begin
      w_state_nxt  = r_state;
      w_shift_nxt  = r_shift;
      w_cnt_nxt    = r_cnt;
      w_ser_nxt    = 1'b0;
      w_valid_nxt  = 1'b0;
      w_done_nxt   = 1'b0;
      w_ready_nxt  = 1'b0;
      w_frames_nxt = r_frames;
      w_last       = 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
      w_parity_nxt = r_parity;
`endif
      case (r_state)
         IDLE: begin
            w_ready_nxt = 1'b1;
         end
         SHIFT: begin
            if (r_cnt != LAST_IDX) begin
               w_cnt_nxt   = r_cnt + CW'(1);
               w_valid_nxt = 1'b1;
               if (MSB_FIRST != 0) begin
                  w_ser_nxt   = r_shift[WIDTH-1];
                  w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
               end else begin
                  w_ser_nxt   = r_shift[0];
                  w_shift_nxt = {1'b0, r_shift[WIDTH-1:1]};
               end
`ifndef SEQ_SERIALIZER_PARITY_EN
               w_done_nxt  = (w_cnt_nxt == LAST_IDX);
               w_ready_nxt = (w_cnt_nxt == LAST_IDX);
`endif
            end else begin
`ifdef SEQ_SERIALIZER_PARITY_EN
               w_state_nxt = PARITY;
               w_ser_nxt   = r_parity;
               w_valid_nxt = 1'b1;
               w_done_nxt  = 1'b1;
               w_ready_nxt = 1'b1;
`else
               w_last      = 1'b1;
               w_state_nxt = IDLE;
               w_ready_nxt = 1'b1;
`endif
            end
         end
`ifdef SEQ_SERIALIZER_PARITY_EN
         PARITY: begin
            w_last      = 1'b1;
            w_state_nxt = IDLE;
            w_ready_nxt = 1'b1;
         end
`endif
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      if (w_last) begin
         w_frames_nxt = r_frames + 8'd1;
      end

      // A new word (possibly in the final cycle) starts immediately with its first bit.
      if (w_accept) begin
         w_state_nxt = SHIFT;
         w_cnt_nxt   = '0;
         w_valid_nxt = 1'b1;
         w_done_nxt  = 1'b0;
         w_ready_nxt = 1'b0;
         if (MSB_FIRST != 0) begin
            w_ser_nxt   = data_in[WIDTH-1];
            w_shift_nxt = {data_in[WIDTH-2:0], 1'b0};
         end else begin
            w_ser_nxt   = data_in[0];
            w_shift_nxt = {1'b0, data_in[WIDTH-1:1]};
         end
`ifdef SEQ_SERIALIZER_PARITY_EN
         w_parity_nxt = ^data_in;
`endif
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_shift  <= '0;
         r_cnt    <= '0;
         r_ser    <= 1'b0;
         r_valid  <= 1'b0;
         r_done   <= 1'b0;
         r_ready  <= 1'b1;
         r_frames <= 8'd0;
`ifdef SEQ_SERIALIZER_PARITY_EN
         r_parity <= 1'b0;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_shift  <= w_shift_nxt;
         r_cnt    <= w_cnt_nxt;
         r_ser    <= w_ser_nxt;
         r_valid  <= w_valid_nxt;
         r_done   <= w_done_nxt;
         r_ready  <= w_ready_nxt;
         r_frames <= w_frames_nxt;
`ifdef SEQ_SERIALIZER_PARITY_EN
         r_parity <= w_parity_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: MSB-first and LSB-first instances, reset abort, back-to-back, wrap.
module tb_seq_serializer;

   localparam int unsigned W = 8;
`ifdef SEQ_SERIALIZER_PARITY_EN
   localparam int unsigned FL = W + 1;
`else
   localparam int unsigned FL = W;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] data_a, data_b;
   logic         lv_a, lv_b;
   logic         rdy_a, ser_a, bv_a, fd_a;
   logic         rdy_b, ser_b, bv_b, fd_b;
   logic [7:0]   fs_a, fs_b;
   int           n_checks = 0;
   int           n_fail   = 0;

   always #5 clk = ~clk;

   seq_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_a (
      .clk(clk), .reset(reset), .data_in(data_a), .load_valid(lv_a),
      .load_ready(rdy_a), .ser_out(ser_a), .bit_valid(bv_a),
      .frame_done(fd_a), .frames_sent(fs_a)
   );

   seq_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_b (
      .clk(clk), .reset(reset), .data_in(data_b), .load_valid(lv_b),
      .load_ready(rdy_b), .ser_out(ser_b), .bit_valid(bv_b),
      .frame_done(fd_b), .frames_sent(fs_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Expected serial bit i of a frame carrying word w (parity bit after the data bits).
   function automatic logic exp_bit(input logic [W-1:0] w, input bit lsb, input int i);
      if (i >= int'(W)) return ^w;
      return lsb ? w[3'(i)] : w[3'(int'(W) - 1 - i)];
   endfunction

   // Called in cycle 1 of a frame; checks every frame cycle and returns in the final one.
   task automatic frame_bits(input logic [W-1:0] w, input bit sel_b, input bit noise, input string tag);
      bit last;
      for (int i = 0; i < int'(FL); i++) begin
         last = (i == int'(FL) - 1);
         check($sformatf("%s_ser%0d", tag, i), 32'(sel_b ? ser_b : ser_a), 32'(exp_bit(w, sel_b, i)));
         check($sformatf("%s_bv%0d", tag, i), 32'(sel_b ? bv_b : bv_a), 32'(1'b1));
         check($sformatf("%s_fd%0d", tag, i), 32'(sel_b ? fd_b : fd_a), 32'(last));
         check($sformatf("%s_rdy%0d", tag, i), 32'(sel_b ? rdy_b : rdy_a), 32'(last));
         if (noise && i == 0) begin
            lv_a   = 1'b1;
            data_a = ~w;
         end
         if (noise && i == int'(FL) - 2) lv_a = 1'b0;
         if (!last) tick();
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      int gaps;
      reset  = 1'b1;
      lv_a   = 1'b0;
      lv_b   = 1'b0;
      data_a = '0;
      data_b = '0;
      #1;
      check("ready_in_reset_t0", 32'(rdy_a), 32'(1'b0));
      tick();
      tick();
      check("rst_ser", 32'(ser_a), 32'(1'b0));
      check("rst_bv", 32'(bv_a), 32'(1'b0));
      check("rst_fd", 32'(fd_a), 32'(1'b0));
      check("rst_fs", 32'(fs_a), 32'(8'd0));
      check("rst_ready", 32'(rdy_a), 32'(1'b0));
      check("rst_ready_b", 32'(rdy_b), 32'(1'b0));
      reset = 1'b0;
      #1;
      check("ready_after_rst", 32'(rdy_a), 32'(1'b1));

      // 8'hD3 MSB first: 1,1,0,1,0,0,1,1 (parity 1 when enabled); data_in changed after accept
      data_a = 8'hD3;
      lv_a   = 1'b1;
      tick();
      lv_a   = 1'b0;
      data_a = 8'h2C;
      frame_bits(8'hD3, 1'b0, 1'b0, "d3");
      check("d3_fs_final", 32'(fs_a), 32'(8'd0));
      tick();
      check("d3_idle_bv", 32'(bv_a), 32'(1'b0));
      check("d3_idle_ser", 32'(ser_a), 32'(1'b0));
      check("d3_idle_fd", 32'(fd_a), 32'(1'b0));
      check("d3_idle_rdy", 32'(rdy_a), 32'(1'b1));
      check("d3_fs", 32'(fs_a), 32'(8'd1));

      // Back-to-back FF then 00, second word accepted in the final cycle of the first
      data_a = 8'hFF;
      lv_a   = 1'b1;
      tick();
      lv_a   = 1'b0;
      frame_bits(8'hFF, 1'b0, 1'b0, "ff");
      data_a = 8'h00;
      lv_a   = 1'b1;
      tick();
      lv_a   = 1'b0;
      data_a = 8'hFF;
      frame_bits(8'h00, 1'b0, 1'b0, "zz");
      check("b2b_fs_pre", 32'(fs_a), 32'(8'd2));
      tick();
      check("b2b_fs", 32'(fs_a), 32'(8'd3));
      check("b2b_idle_bv", 32'(bv_a), 32'(1'b0));

      // load_valid while busy must be ignored
      data_a = 8'h5A;
      lv_a   = 1'b1;
      tick();
      lv_a   = 1'b0;
      frame_bits(8'h5A, 1'b0, 1'b1, "busy");
      tick();
      check("busy_fs", 32'(fs_a), 32'(8'd4));
      check("busy_idle_bv", 32'(bv_a), 32'(1'b0));

      // LSB-first instance: 8'h06 -> 0,1,1,0,0,0,0,0
      data_b = 8'h06;
      lv_b   = 1'b1;
      tick();
      lv_b   = 1'b0;
      frame_bits(8'h06, 1'b1, 1'b0, "lsb");
      tick();
      check("lsb_fs", 32'(fs_b), 32'(8'd1));
      check("lsb_idle_bv", 32'(bv_b), 32'(1'b0));

      // Reset after three bits of D3 aborts the frame
      data_a = 8'hD3;
      lv_a   = 1'b1;
      tick();
      lv_a   = 1'b0;
      check("abort_b0", 32'(ser_a), 32'(1'b1));
      tick();
      check("abort_b1", 32'(ser_a), 32'(1'b1));
      tick();
      check("abort_b2", 32'(ser_a), 32'(1'b0));
      reset = 1'b1;
      tick();
      check("abort_bv", 32'(bv_a), 32'(1'b0));
      check("abort_ser", 32'(ser_a), 32'(1'b0));
      check("abort_fd", 32'(fd_a), 32'(1'b0));
      check("abort_fs", 32'(fs_a), 32'(8'd0));
      check("abort_rdy_in_rst", 32'(rdy_a), 32'(1'b0));
      reset = 1'b0;
      #1;
      check("abort_rdy_after", 32'(rdy_a), 32'(1'b1));
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (fd_a || bv_a) pulses++;
      end
      check("abort_no_activity", 32'(pulses), 32'd0);
      check("abort_fs_after", 32'(fs_a), 32'(8'd0));

      // 256 back-to-back frames wrap the frame counter
      data_a = 8'hA5;
      lv_a   = 1'b1;
      pulses = 0;
      gaps   = 0;
      for (int f = 0; f < 256; f++) begin
         for (int c = 0; c < int'(FL); c++) begin
            tick();
            if (fd_a) pulses++;
            if (!bv_a) gaps++;
         end
      end
      check("wrap_fs_255", 32'(fs_a), 32'(8'd255));
      check("wrap_pulses", 32'(pulses), 32'd256);
      check("wrap_gaps", 32'(gaps), 32'd0);
      lv_a = 1'b0;
      tick();
      check("wrap_fs_0", 32'(fs_a), 32'(8'd0));
      check("wrap_idle_bv", 32'(bv_a), 32'(1'b0));
      check("wrap_idle_rdy", 32'(rdy_a), 32'(1'b1));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_serializer.md
SEQ_SERIALIZER -- requirements
Module: seq_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 sent first, 0 = bit 0 sent first.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port data_in  input  WIDTH  parallel word to serialize.
REQ-006 SHALL have port load_valid  input  1  data_in holds a valid word.
REQ-007 SHALL have port load_ready  output  1  block accepts a word this cycle.
REQ-008 SHALL have port ser_out  output  1  serial bit stream, drives the sequence detector's in_seq.
REQ-009 SHALL have port bit_valid  output  1  ser_out carries a frame bit this cycle.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse on the last bit of a frame.
REQ-011 SHALL have port frames_sent  output  8  count of completed frames.

Function
REQ-012 SHALL accept a word only on a rising edge where load_valid && load_ready; load_valid without load_ready SHALL be ignored.
REQ-013 SHALL implement FSM states IDLE, SHIFT (plus PARITY when PARITY_EN is defined); IDLE->SHIFT on accept; SHIFT->IDLE after the last bit when no new word is accepted.
REQ-014 SHALL present the first bit of an accepted word on ser_out in the cycle after the accepting edge, one bit per cycle for WIDTH consecutive cycles, ser_out and bit_valid registered.
REQ-015 SHALL hold bit_valid = 1 for every frame bit and 0 in IDLE; ser_out SHALL be 0 in IDLE.
REQ-016 SHALL drive load_ready = 1 in IDLE and during the final bit cycle of a frame, 0 otherwise; a word accepted in the final bit cycle SHALL start on the next cycle with no gap (bit_valid stays 1).
REQ-017 SHALL capture data_in into an internal shift register at accept; later changes of data_in SHALL not affect the frame in progress.
REQ-018 SHALL pulse frame_done high for exactly the final bit cycle of each frame.
REQ-019 SHALL increment frames_sent by 1 on the edge ending each frame, wrapping 255 -> 0.
REQ-020 SHALL hold load_ready = 0 while reset is high.

Reset
REQ-021 SHALL, on reset high at a rising edge, force state IDLE, ser_out = 0, bit_valid = 0, frame_done = 0, frames_sent = 0, shift register = 0.
REQ-022 SHALL, on reset mid-frame, abort the frame without frame_done or frames_sent increment; load_ready = 1 in the first cycle after reset deasserts.

Configuration
REQ-023 SHALL, with macro SEQ_SERIALIZER_PARITY_EN defined, append one even-parity bit (XOR of the WIDTH data bits) after the data bits with bit_valid = 1, making frames WIDTH+1 cycles; load_ready and frame_done then apply to the parity cycle instead of the last data bit.
REQ-024 SHALL, without SEQ_SERIALIZER_PARITY_EN, have no PARITY state and WIDTH-cycle frames.

Verification
REQ-025 WIDTH=8, MSB_FIRST=1, load 8'hD3 -> ser_out 1,1,0,1,0,0,1,1 on cycles 1..8 after accept, bit_valid 1 throughout, frame_done on cycle 8, frames_sent 0->1.
REQ-026 Back-to-back 8'hFF then 8'h00 (second accepted on cycle 8) -> 16 contiguous valid bits 1x8 then 0x8, frame_done on cycles 8 and 16, frames_sent = 2.
REQ-027 MSB_FIRST=0, load 8'h06 -> ser_out 0,1,1,0,0,0,0,0.
REQ-028 SEQ_SERIALIZER_PARITY_EN defined, load 8'hD3 -> 8 data bits then parity bit 1 on cycle 9, frame_done on cycle 9 only.
REQ-029 Reset asserted after 3 bits of 8'hD3 -> next cycle bit_valid 0, ser_out 0, frames_sent 0, frame_done never pulses; load_ready 1 after reset deasserts.
REQ-030 256 back-to-back frames -> frames_sent wraps to 0 after the 256th frame_done.
